// File: rtl/stream_sink.sv
`default_nettype none
// ============================================================================
// Module   : stream_sink
// Purpose  : Consumer endpoint for an 8-bit valid/ready stream. It drives
//            programmable backpressure, checks received data against an
//            incrementing sequence and checks handshake compliance. It stops
//            accepting beats after a programmed number of beats.
// Ports    : clk, reset (sync, active-low)
//            s_valid_i/s_data_i/s_ready_o : upstream stream handshake
//            stall_mode_i : 0 ready, 1 never, 2 alternate, 3 LFSR
//            seed_i, exp_init_i, num_beats_i, start_i : run configuration
//            beat_cnt_o, err_cnt_o, mismatch_o, proto_err_o, done_o,
//            last_data_o : status
// Revision : 1.0 - initial release
// ============================================================================
module stream_sink #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid_i,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              s_ready_o,
  input  logic [1:0]        stall_mode_i,
  input  logic [7:0]        seed_i,
  input  logic [DATA_W-1:0] exp_init_i,
  input  logic [CNT_W-1:0]  num_beats_i,
  input  logic              start_i,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              mismatch_o,
  output logic              proto_err_o,
  output logic              done_o,
  output logic [DATA_W-1:0] last_data_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [7:0]       C_LFSR_ONE = 8'h01;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  err_q, err_d;
  logic              mismatch_q, mismatch_d;
  logic              proto_q, proto_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] last_q, last_d;
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              toggle_q, toggle_d;
  logic              stall_q, stall_d;
  logic [DATA_W-1:0] stall_data_q, stall_data_d;

  logic              run_w;
  logic              accept_w;
  logic              gate_w;

  assign run_w    = (state_q == ST_RUN);
  // start_i wins over a coincident handshake: that beat is dropped uncounted.
  assign accept_w = run_w & s_valid_i & ready_q & ~start_i;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    err_d        = err_q;
    mismatch_d   = mismatch_q;
    proto_d      = proto_q;
    done_d       = done_q;
    last_d       = last_q;
    exp_d        = exp_q;
    lfsr_d       = lfsr_q;
    toggle_d     = toggle_q;
    stall_d      = 1'b0;
    stall_data_d = stall_data_q;

    if (start_i) begin
      state_d    = ST_RUN;
      beat_d     = '0;
      err_d      = '0;
      mismatch_d = 1'b0;
      proto_d    = 1'b0;
      done_d     = 1'b0;
      exp_d      = exp_init_i;
      // An all-zero LFSR would lock up, so a zero seed is remapped.
      lfsr_d     = (seed_i == 8'h00) ? C_LFSR_ONE : seed_i;
      toggle_d   = 1'b1;
    end else if (run_w) begin
      toggle_d = ~toggle_q;
      lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

      // A beat offered while stalled must be re-offered unchanged.
      if (stall_q && (!s_valid_i || (s_data_i != stall_data_q))) begin
        proto_d = 1'b1;
      end
      stall_d      = s_valid_i & ~ready_q;
      stall_data_d = s_data_i;

      if (accept_w) begin
        beat_d = (beat_q == C_CNT_MAX) ? beat_q : beat_q + CNT_W'(1);
        last_d = s_data_i;
        if (s_data_i != exp_q) begin
          err_d      = (err_q == C_CNT_MAX) ? err_q : err_q + CNT_W'(1);
          mismatch_d = 1'b1;
        end
        // Resync on the received value so a single gap costs one error.
        exp_d = s_data_i + DATA_W'(1);
        if ((num_beats_i != '0) && (beat_d == num_beats_i)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    end

    // Gate is taken from the next toggle/LFSR value so that the registered
    // ready always equals the gate of the registers it is launched with.
    case (stall_mode_i)
      2'd0:    gate_w = 1'b1;
      2'd1:    gate_w = 1'b0;
      2'd2:    gate_w = toggle_d;
      default: gate_w = lfsr_d[0];
    endcase
    ready_d = (state_d == ST_RUN) & gate_w;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      beat_q       <= '0;
      err_q        <= '0;
      mismatch_q   <= 1'b0;
      proto_q      <= 1'b0;
      done_q       <= 1'b0;
      last_q       <= '0;
      exp_q        <= '0;
      lfsr_q       <= C_LFSR_ONE;
      toggle_q     <= 1'b1;
      stall_q      <= 1'b0;
      stall_data_q <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      beat_q       <= beat_d;
      err_q        <= err_d;
      mismatch_q   <= mismatch_d;
      proto_q      <= proto_d;
      done_q       <= done_d;
      last_q       <= last_d;
      exp_q        <= exp_d;
      lfsr_q       <= lfsr_d;
      toggle_q     <= toggle_d;
      stall_q      <= stall_d;
      stall_data_q <= stall_data_d;
    end
  end

  assign s_ready_o   = ready_q;
  assign beat_cnt_o  = beat_q;
  assign err_cnt_o   = err_q;
  assign mismatch_o  = mismatch_q;
  assign proto_err_o = proto_q;
  assign done_o      = done_q;
  assign last_data_o = last_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_sink
// Purpose  : Self-checking bench for stream_sink: directed vector table,
//            hand-written ready-pattern sequences and randomized traffic
//            compared every cycle against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_sink;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid_i;
  logic [7:0]  s_data_i;
  logic        s_ready_o;
  logic [1:0]  stall_mode_i;
  logic [7:0]  seed_i;
  logic [7:0]  exp_init_i;
  logic [15:0] num_beats_i;
  logic        start_i;
  logic [15:0] beat_cnt_o, err_cnt_o;
  logic        mismatch_o, proto_err_o, done_o;
  logic [7:0]  last_data_o;

  int n_vec = 0;
  int n_err = 0;

  stream_sink #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .stall_mode_i(stall_mode_i), .seed_i(seed_i), .exp_init_i(exp_init_i),
    .num_beats_i(num_beats_i), .start_i(start_i),
    .beat_cnt_o(beat_cnt_o), .err_cnt_o(err_cnt_o), .mismatch_o(mismatch_o),
    .proto_err_o(proto_err_o), .done_o(done_o), .last_data_o(last_data_o)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  int          m_state;      // 0 idle, 1 run, 2 done
  int          m_k;          // cycles elapsed since start
  logic [7:0]  m_seed;
  logic        m_ready;
  logic [15:0] m_beat, m_err;
  logic        m_mis, m_proto, m_done;
  logic [7:0]  m_last, m_exp, m_stall_data;
  logic        m_stall;

  // Register value of x^8+x^6+x^5+x^4+1 Fibonacci sequence after k shifts.
  function automatic logic [7:0] lfsr_at(input logic [7:0] s, input int k);
    logic [7:0] v;
    v = (s == 8'h00) ? 8'h01 : s;
    for (int i = 0; i < k; i++) v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    return v;
  endfunction

  function automatic logic gate_at(input logic [1:0] mode, input logic [7:0] s, input int k);
    logic [7:0] v;
    case (mode)
      2'd0: return 1'b1;
      2'd1: return 1'b0;
      2'd2: return (k % 2) == 0;
      default: begin
        v = lfsr_at(s, k);
        return v[0];
      end
    endcase
  endfunction

  task automatic model_step();
    logic acc;
    if (!reset) begin
      m_state = 0; m_k = 0; m_ready = 0; m_beat = 0; m_err = 0;
      m_mis = 0; m_proto = 0; m_done = 0; m_last = 0; m_exp = 0; m_stall = 0;
    end else if (start_i) begin
      m_state = 1; m_k = 0; m_beat = 0; m_err = 0; m_mis = 0; m_proto = 0;
      m_done = 0; m_exp = exp_init_i; m_seed = seed_i; m_stall = 0;
      m_ready = gate_at(stall_mode_i, m_seed, 0);
    end else if (m_state == 1) begin
      acc = s_valid_i && m_ready;
      if (m_stall && (!s_valid_i || s_data_i != m_stall_data)) m_proto = 1;
      m_stall      = s_valid_i && !m_ready;
      m_stall_data = s_data_i;
      if (acc) begin
        if (m_beat != 16'hFFFF) m_beat = m_beat + 1;
        m_last = s_data_i;
        if (s_data_i != m_exp) begin
          if (m_err != 16'hFFFF) m_err = m_err + 1;
          m_mis = 1;
        end
        m_exp = s_data_i + 8'd1;
        if (num_beats_i != 0 && m_beat == num_beats_i) begin
          m_state = 2; m_done = 1;
        end
      end
      m_k++;
      m_ready = (m_state == 1) ? gate_at(stall_mode_i, m_seed, m_k) : 1'b0;
    end else begin
      m_stall = 0;
    end
  endtask

  function automatic logic [43:0] dut_vec();
    return {s_ready_o, beat_cnt_o, err_cnt_o, mismatch_o, proto_err_o, done_o, last_data_o};
  endfunction

  task automatic check(input string name, input logic [43:0] got, input logic [43:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @%0t: got {rdy,beat,err,mis,proto,done,last}=%h want %h",
               name, $time, got, want);
    end
  endtask

  // One clock: advance the model on the current inputs, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("model", dut_vec(),
          {m_ready, m_beat, m_err, m_mis, m_proto, m_done, m_last});
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst_n, start, valid;
    logic [7:0]  data;
    logic [1:0]  mode;
    logic [7:0]  exp_init;
    logic [15:0] nb;
    logic        e_ready;
    logic [15:0] e_beat, e_err;
    logic        e_mis, e_proto, e_done;
    logic [7:0]  e_last;
  } vec_t;

  localparam int NROWS = 28;
  vec_t tbl [NROWS];

  initial begin
    logic [7:0] d;
    logic       acc, held;
    int         rdy_cycles;

    //           rst st  v  data   md  exp    nb      rdy beat    err     mis pro don last
    tbl[0]  = '{1'b0,1'b0,1'b0,8'h00,2'd0,8'h10,16'd4, 1'b0,16'd0,16'd0,1'b0,1'b0,1'b0,8'h00};
    tbl[1]  = '{1'b1,1'b1,1'b0,8'h00,2'd0,8'h10,16'd4, 1'b1,16'd0,16'd0,1'b0,1'b0,1'b0,8'h00};
    tbl[2]  = '{1'b1,1'b0,1'b1,8'h10,2'd0,8'h10,16'd4, 1'b1,16'd1,16'd0,1'b0,1'b0,1'b0,8'h10};
    tbl[3]  = '{1'b1,1'b0,1'b1,8'h11,2'd0,8'h10,16'd4, 1'b1,16'd2,16'd0,1'b0,1'b0,1'b0,8'h11};
    tbl[4]  = '{1'b1,1'b0,1'b1,8'h12,2'd0,8'h10,16'd4, 1'b1,16'd3,16'd0,1'b0,1'b0,1'b0,8'h12};
    tbl[5]  = '{1'b1,1'b0,1'b1,8'h13,2'd0,8'h10,16'd4, 1'b0,16'd4,16'd0,1'b0,1'b0,1'b1,8'h13};
    tbl[6]  = '{1'b1,1'b0,1'b1,8'h14,2'd0,8'h10,16'd4, 1'b0,16'd4,16'd0,1'b0,1'b0,1'b1,8'h13};
    tbl[7]  = '{1'b1,1'b1,1'b0,8'h00,2'd0,8'hFE,16'd0, 1'b1,16'd0,16'd0,1'b0,1'b0,1'b0,8'h13};
    tbl[8]  = '{1'b1,1'b0,1'b1,8'hFE,2'd0,8'hFE,16'd0, 1'b1,16'd1,16'd0,1'b0,1'b0,1'b0,8'hFE};
    tbl[9]  = '{1'b1,1'b0,1'b1,8'hFF,2'd0,8'hFE,16'd0, 1'b1,16'd2,16'd0,1'b0,1'b0,1'b0,8'hFF};
    tbl[10] = '{1'b1,1'b0,1'b1,8'h00,2'd0,8'hFE,16'd0, 1'b1,16'd3,16'd0,1'b0,1'b0,1'b0,8'h00};
    tbl[11] = '{1'b1,1'b0,1'b1,8'h05,2'd0,8'hFE,16'd0, 1'b1,16'd4,16'd1,1'b1,1'b0,1'b0,8'h05};
    tbl[12] = '{1'b1,1'b0,1'b1,8'h06,2'd0,8'hFE,16'd0, 1'b1,16'd5,16'd1,1'b1,1'b0,1'b0,8'h06};
    tbl[13] = '{1'b1,1'b1,1'b0,8'h00,2'd1,8'h00,16'd0, 1'b0,16'd0,16'd0,1'b0,1'b0,1'b0,8'h06};
    tbl[14] = '{1'b1,1'b0,1'b1,8'h20,2'd1,8'h00,16'd0, 1'b0,16'd0,16'd0,1'b0,1'b0,1'b0,8'h06};
    tbl[15] = '{1'b1,1'b0,1'b1,8'h20,2'd1,8'h00,16'd0, 1'b0,16'd0,16'd0,1'b0,1'b0,1'b0,8'h06};
    tbl[16] = '{1'b1,1'b0,1'b1,8'h21,2'd1,8'h00,16'd0, 1'b0,16'd0,16'd0,1'b0,1'b1,1'b0,8'h06};
    tbl[17] = '{1'b1,1'b1,1'b0,8'h00,2'd1,8'h00,16'd0, 1'b0,16'd0,16'd0,1'b0,1'b0,1'b0,8'h06};
    tbl[18] = '{1'b1,1'b0,1'b1,8'h30,2'd1,8'h00,16'd0, 1'b0,16'd0,16'd0,1'b0,1'b0,1'b0,8'h06};
    tbl[19] = '{1'b1,1'b0,1'b0,8'h30,2'd1,8'h00,16'd0, 1'b0,16'd0,16'd0,1'b0,1'b1,1'b0,8'h06};
    tbl[20] = '{1'b1,1'b1,1'b0,8'h00,2'd0,8'h40,16'd0, 1'b1,16'd0,16'd0,1'b0,1'b0,1'b0,8'h06};
    tbl[21] = '{1'b1,1'b0,1'b1,8'h40,2'd0,8'h40,16'd0, 1'b1,16'd1,16'd0,1'b0,1'b0,1'b0,8'h40};
    tbl[22] = '{1'b1,1'b0,1'b1,8'h41,2'd0,8'h40,16'd0, 1'b1,16'd2,16'd0,1'b0,1'b0,1'b0,8'h41};
    tbl[23] = '{1'b1,1'b0,1'b1,8'h42,2'd0,8'h40,16'd0, 1'b1,16'd3,16'd0,1'b0,1'b0,1'b0,8'h42};
    tbl[24] = '{1'b0,1'b0,1'b1,8'h43,2'd0,8'h40,16'd0, 1'b0,16'd0,16'd0,1'b0,1'b0,1'b0,8'h00};
    tbl[25] = '{1'b1,1'b1,1'b0,8'h00,2'd0,8'h50,16'd0, 1'b1,16'd0,16'd0,1'b0,1'b0,1'b0,8'h00};
    tbl[26] = '{1'b1,1'b1,1'b1,8'h50,2'd0,8'h60,16'd0, 1'b1,16'd0,16'd0,1'b0,1'b0,1'b0,8'h00};
    tbl[27] = '{1'b1,1'b0,1'b1,8'h60,2'd0,8'h60,16'd0, 1'b1,16'd1,16'd0,1'b0,1'b0,1'b0,8'h60};

    reset = 1'b0; start_i = 1'b0; s_valid_i = 1'b0; s_data_i = 8'h00;
    stall_mode_i = 2'd0; seed_i = 8'h01; exp_init_i = 8'h00; num_beats_i = 16'd0;

    for (int i = 0; i < NROWS; i++) begin
      reset = tbl[i].rst_n; start_i = tbl[i].start; s_valid_i = tbl[i].valid;
      s_data_i = tbl[i].data; stall_mode_i = tbl[i].mode;
      exp_init_i = tbl[i].exp_init; num_beats_i = tbl[i].nb;
      tick();
      check($sformatf("table[%0d]", i), dut_vec(),
            {tbl[i].e_ready, tbl[i].e_beat, tbl[i].e_err, tbl[i].e_mis,
             tbl[i].e_proto, tbl[i].e_done, tbl[i].e_last});
    end

    // Alternate mode: ready 1,0,1,0 from the cycle after start.
    reset = 1'b1; start_i = 1'b1; s_valid_i = 1'b0; stall_mode_i = 2'd2;
    exp_init_i = 8'h80; num_beats_i = 16'd0; d = 8'h80;
    tick();
    start_i = 1'b0;
    check("m2_first_ready", {43'd0, s_ready_o}, 44'd1);
    for (int i = 1; i <= 12; i++) begin
      s_valid_i = 1'b1; s_data_i = d; acc = s_ready_o;
      tick();
      if (acc) d = d + 8'd1;
      check($sformatf("m2_ready[%0d]", i), {43'd0, s_ready_o}, {43'd0, (i % 2) == 0});
    end
    check("m2_beats", {28'd0, beat_cnt_o}, {28'd0, 16'd6});
    check("m2_errs", {28'd0, err_cnt_o}, 44'd0);

    // LFSR mode with a zero seed behaves as seed 1.
    start_i = 1'b1; s_valid_i = 1'b0; stall_mode_i = 2'd3; seed_i = 8'h00;
    exp_init_i = 8'h00; d = 8'h00; rdy_cycles = 0;
    tick();
    start_i = 1'b0;
    check("m3_first_ready", {43'd0, s_ready_o}, 44'd1);
    for (int i = 0; i < 32; i++) begin
      s_valid_i = 1'b1; s_data_i = d; acc = s_ready_o;
      if (acc) rdy_cycles++;
      tick();
      if (acc) d = d + 8'd1;
    end
    check("m3_accepts", {28'd0, beat_cnt_o}, {28'd0, 16'(rdy_cycles)});
    check("m3_errs", {28'd0, err_cnt_o}, 44'd0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 60; r++) begin
      reset = 1'b1; start_i = 1'b1;
      stall_mode_i = 2'($urandom_range(0, 3));
      seed_i = (r % 7 == 0) ? 8'h00 : 8'($urandom);
      exp_init_i = 8'($urandom);
      num_beats_i = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 20));
      s_valid_i = 1'($urandom); s_data_i = 8'($urandom);
      d = exp_init_i; held = 1'b0;
      tick();
      for (int c = 0; c < 40; c++) begin
        reset   = ($urandom_range(0, 99) != 0);
        start_i = ($urandom_range(0, 79) == 0);
        if (!(held && $urandom_range(0, 9) != 0)) begin
          s_valid_i = ($urandom_range(0, 9) < 7);
          s_data_i  = ($urandom_range(0, 11) == 0) ? 8'($urandom) : d;
        end
        acc  = s_valid_i & s_ready_o;
        held = s_valid_i & ~s_ready_o;
        tick();
        if (acc) d = s_data_i + 8'd1;
      end
      start_i = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_sink.md
Name: stream_sink

Overview:
- Consumer-side endpoint for the 8-bit valid/ready stream that the pipeline and skid-buffer stages emit.
- Drives programmable backpressure on ready, checks the received data against an incrementing sequence, checks handshake protocol compliance, and stops after a programmed number of beats.
- Used as the egress terminator in block-level and integration testbenches, and as a synthesizable on-chip traffic checker.

Parameters:
DATA_W, 8, width of stream data and expected-value register
CNT_W, 16, width of beat/error counters and beat limit

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
s_valid_i  input  1  upstream valid
s_data_i  input  DATA_W  upstream data
s_ready_o  output  1  ready to upstream, registered
stall_mode_i  input  2  0 always ready, 1 never ready, 2 alternate, 3 pseudo-random
seed_i  input  8  LFSR seed loaded on start
exp_init_i  input  DATA_W  first expected data value, loaded on start
num_beats_i  input  CNT_W  beats to accept before DONE; 0 = unlimited
start_i  input  1  single-cycle pulse: clear status, enter RUN
beat_cnt_o  output  CNT_W  accepted beats, saturating
err_cnt_o  output  CNT_W  data mismatches, saturating
mismatch_o  output  1  sticky, any data mismatch since start
proto_err_o  output  1  sticky, handshake rule violated since start
done_o  output  1  high in DONE state
last_data_o  output  DATA_W  data of the most recent accepted beat

Behaviour:
- Reset (reset==0 at a clock edge): state IDLE; s_ready_o=0; all counters, flags, done_o, last_data_o=0; expected=0; LFSR=8'h01; toggle flop=1; stall tracker cleared.
- FSM states:
  - IDLE: ready 0.
  - RUN: ready per mode.
  - DONE: ready 0, done_o=1.
- Transitions:
  - start_i in any state -> RUN.
  - RUN -> DONE on the accept that makes beat_cnt equal num_beats_i (num_beats_i != 0).
  - DONE and IDLE hold until start_i.
- start_i effects, next cycle: counters=0, flags=0, done_o=0, expected=exp_init_i, LFSR=seed_i (8'h00 replaced by 8'h01), toggle=1, stall tracker cleared.
- s_ready_o is a flop. Its next value = (next_state==RUN) & gate, where gate per mode is:
  - mode 0: 1.
  - mode 1: 0.
  - mode 2: toggle flop. It inverts every cycle in RUN. First ready after start is 1, giving pattern 1,0,1,0...
  - mode 3: LFSR bit0. Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1, shifted every cycle in RUN.
- s_ready_o never depends combinationally on s_valid_i.
- Accept = s_valid_i & s_ready_o while in RUN. On accept:
  - beat_cnt +1, saturating at 2^CNT_W-1.
  - last_data_o = s_data_i.
  - If s_data_i != expected: err_cnt +1 (saturating) and mismatch_o set.
  - expected = s_data_i + 1, mod 2^DATA_W, i.e. resync so one discontinuity gives one error. 8'hFF is followed by 8'h00.
- Ready deasserts in the cycle after the final accept, so no beat is accepted in DONE.
- start_i coinciding with a handshake: start has priority. The beat is consumed on the bus but not counted, not checked and not stored.
- Protocol check, RUN only:
  - Track a stall as s_valid_i & ~s_ready_o in the previous cycle.
  - If a stall was tracked, the current cycle must have s_valid_i=1 and s_data_i equal to the stalled data. Otherwise set proto_err_o.
  - The tracker clears on accept, start or reset.
- Status outputs hold their values in IDLE and DONE.
- Reset mid-RUN returns to IDLE immediately on that edge; the transfer in flight is dropped.
- Latency: start_i at cycle t -> state RUN and first possible s_ready_o=1 at t+1.

Test Plan:
- Mode 0, exp_init=8'h10, num_beats=4, upstream sends 10,11,12,13 back-to-back -> beat_cnt=4, err_cnt=0, done_o=1 the cycle after the 4th accept, s_ready_o=0 from then on.
- Mode 2 with continuous valid -> s_ready_o pattern 1,0,1,0 from t+1 after start; 6 beats accepted in 12 cycles.
- Mode 0, sequence FE,FF,00,05,06 with exp_init=FE -> err_cnt=1, mismatch_o=1, last_data_o=06.
- Mode 1 with valid held, then data changed while stalled -> proto_err_o=1, beat_cnt=0. Same run with valid dropped without data change -> proto_err_o=1.
- Mode 3 seed=8'h00 -> behaves as seed 8'h01. The ready sequence matches the reference LFSR model for 32 cycles, and the count of accepts equals the count of ready cycles under continuous valid.
- reset=0 mid-RUN after 3 beats -> next cycle s_ready_o=0, beat_cnt=0, state IDLE. start_i with a simultaneous handshake -> that beat is not counted.
